// File: rtl/matrix_pkg.sv
`default_nettype none
// == matrix_pkg : shared state encoding, pixel-word layout and defaults for the HUB75 scan controller (rev 1.0) ==
package matrix_pkg;

    localparam int DEF_COLS       = 64;
    localparam int DEF_ROWS       = 16;
    localparam int DEF_BITS       = 4;
    localparam int DEF_BASE_TICKS = 8;

    // Field index within a frame-buffer word; each field is BITS wide, r0 in the LSBs.
    localparam int NUM_FIELDS = 6;
    localparam int FLD_R0     = 0;
    localparam int FLD_G0     = 1;
    localparam int FLD_B0     = 2;
    localparam int FLD_R1     = 3;
    localparam int FLD_G1     = 4;
    localparam int FLD_B1     = 5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREFETCH = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_LATCH    = 3'd3,
        ST_DISPLAY  = 3'd4
    } state_t;

    function automatic int field_lsb(input int fld, input int bits);
        return fld * bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcm_timer.sv
`default_nettype none
// == bcm_timer : loadable down-counter timing one BCM display period (rev 1.0) ==
module bcm_timer #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             active,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign active = (count != '0);
    assign done   = (count == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/matrix_scan_ctrl.sv
`default_nettype none
// == matrix_scan_ctrl : HUB75 64x32 scan sequencer with binary-code-modulated colour depth (rev 1.0) ==
module matrix_scan_ctrl
    import matrix_pkg::*;
#(
    parameter  int COLS       = DEF_COLS,
    parameter  int ROWS       = DEF_ROWS,
    parameter  int BITS       = DEF_BITS,
    parameter  int BASE_TICKS = DEF_BASE_TICKS,
    localparam int ROW_W      = $clog2(ROWS),
    localparam int COL_W      = $clog2(COLS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    output logic [ROW_W+COL_W-1:0] rd_addr,
    input  logic [6*BITS-1:0]      rd_data,
    output logic                   r0,
    output logic                   g0,
    output logic                   b0,
    output logic                   r1,
    output logic                   g1,
    output logic                   b1,
    output logic                   a,
    output logic                   b,
    output logic                   c,
    output logic                   d,
    output logic                   clkout,
    output logic                   stb,
    output logic                   oe,
    output logic                   frame_done,
    output logic                   busy
);

    localparam int PLANE_W = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int SH_W    = $clog2(2 * COLS);
    localparam int CNT_W   = $clog2(BASE_TICKS << (BITS - 1)) + 1;

    state_t                  state;
    logic [ROW_W-1:0]        row;
    logic [ROW_W-1:0]        row_latched;
    logic [PLANE_W-1:0]      plane;
    logic [SH_W-1:0]         shift_cnt;
    logic [NUM_FIELDS-1:0]   colour_q;
    logic [NUM_FIELDS-1:0]   pix_bits;
    logic [NUM_FIELDS-1:0]   colour_now;
    logic [BITS-1:0]         fld;
    logic                    frame_done_q;
    logic                    tmr_active;
    logic                    tmr_done;
    logic                    shift_even;
    logic                    last_shift;
    logic                    last_plane;
    logic                    last_row;
    logic [COL_W-1:0]        col_idx;
    logic [COL_W-1:0]        next_col;
    logic [ROW_W-1:0]        row_shown;

    assign col_idx    = shift_cnt[SH_W-1:1];
    assign shift_even = (state == ST_SHIFT) && !shift_cnt[0];
    assign last_shift = (shift_cnt == SH_W'(2 * COLS - 1));
    assign last_plane = (plane == PLANE_W'(BITS - 1));
    assign last_row   = (row == ROW_W'(ROWS - 1));
    assign next_col   = (col_idx == COL_W'(COLS - 1)) ? '0 : col_idx + 1'b1;

    always_comb begin
        fld      = '0;
        pix_bits = '0;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            fld         = rd_data[field_lsb(f, BITS) +: BITS];
            pix_bits[f] = fld[plane];
        end
    end

    // Pixel data arrives combinationally on even shift cycles and is held through the rising clkout.
    assign colour_now = shift_even ? pix_bits : colour_q;
    assign {b1, g1, r1, b0, g0, r0} = colour_now;

    assign rd_addr = {row, (state == ST_SHIFT) ? next_col : {COL_W{1'b0}}};

    // Panel row lines follow the new row only from the latch cycle onwards, never while lit.
    assign row_shown    = (state == ST_LATCH) ? row : row_latched;
    assign {d, c, b, a} = 4'(row_shown);

    assign clkout     = (state == ST_SHIFT) && shift_cnt[0];
    assign stb        = (state == ST_LATCH);
    assign oe         = ~tmr_active;
    assign busy       = (state != ST_IDLE);
    assign frame_done = frame_done_q;

    bcm_timer #(
        .CNT_W(CNT_W)
    ) u_bcm_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (state == ST_LATCH),
        .load_value(CNT_W'(BASE_TICKS) << plane),
        .active    (tmr_active),
        .done      (tmr_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            row          <= '0;
            row_latched  <= '0;
            plane        <= '0;
            shift_cnt    <= '0;
            colour_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (shift_even) begin
                colour_q <= pix_bits;
            end
            case (state)
                ST_IDLE: begin
                    if (enable) state <= ST_PREFETCH;
                end
                ST_PREFETCH: begin
                    shift_cnt <= '0;
                    state     <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    shift_cnt <= shift_cnt + 1'b1;
                    if (last_shift) state <= ST_LATCH;
                end
                ST_LATCH: begin
                    row_latched <= row;
                    state       <= ST_DISPLAY;
                end
                ST_DISPLAY: begin
                    if (tmr_done) begin
                        if (!last_plane) begin
                            plane <= plane + 1'b1;
                            state <= ST_PREFETCH;
                        end else begin
                            plane <= '0;
                            if (!last_row) begin
                                row   <= row + 1'b1;
                                state <= ST_PREFETCH;
                            end else begin
                                // enable is only consulted here and in IDLE, so a frame always completes.
                                row          <= '0;
                                frame_done_q <= 1'b1;
                                state        <= enable ? ST_PREFETCH : ST_IDLE;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/matrix_scan_ctrl.md
# matrix_scan_ctrl

Scan controller for the 64×32 HUB75 LED panel (two 16-row halves driven in parallel). It sequences column shifting, latching, row addressing and output-enable timing. It reads pixel colour from an external frame-buffer port and displays `BITS`-deep colour per channel using binary-code modulation (BCM). It sits between the frame buffer and the panel pins.

## Interface
Parameters:
- `COLS`, 64, columns shifted per row
- `ROWS`, 16, row addresses per half-panel (power of two; `ROW_W = log2(ROWS)`)
- `BITS`, 4, colour depth per channel (bit planes)
- `BASE_TICKS`, 8, display cycles for plane 0; plane p displays `BASE_TICKS << p`

Ports:
- `clk` in 1: system clock. One clock domain; everything is rising-edge.
- `reset` in 1: asynchronous, active-low.
- `enable` in 1: level input; run scanning while high.
- `rd_addr` out `ROW_W+log2(COLS)`: frame-buffer address `{row, col}`.
- `rd_data` in `6*BITS`: pixel pair, valid one cycle after `rd_addr`. Layout LSB-first: `r0, g0, b0, r1, g1, b1`, each `BITS` wide.
- `r0 g0 b0 r1 g1 b1` out 1 each: panel colour data, upper/lower half.
- `a b c d` out 1 each: row address bits 0..3.
- `clkout` out 1: panel shift clock.
- `stb` out 1: latch pulse, active-high.
- `oe` out 1: panel blank. 1 = LEDs off.
- `frame_done` out 1: one-cycle pulse after the last plane of row `ROWS-1`.
- `busy` out 1: high whenever not in IDLE.

## Operation
- State machine states: IDLE, PREFETCH, SHIFT, LATCH, DISPLAY.
- **IDLE**
  - `oe=1`; go to PREFETCH when `enable=1`.
  - Row and plane counters are 0 on entry.
- **PREFETCH** (1 cycle)
  - Drive `rd_addr={row,0}`.
- **SHIFT** (`2*COLS` cycles, column k = 0..COLS-1)
  - Cycle 2k: `clkout=0`. Colour outputs take bit `plane` of each `rd_data` field. `rd_addr={row,k+1}` (wraps to `{row,0}` at k = COLS-1; value is don't-care).
  - Cycle 2k+1: `clkout=1`, colour outputs held.
- **LATCH** (1 cycle)
  - `oe=1`, `stb=1`, `clkout=0`.
  - `a..d` update to the current row in this cycle.
- **DISPLAY** (`BASE_TICKS<<plane` cycles)
  - `oe=0`, `stb=0`.
- **End of DISPLAY**
  - If `plane<BITS-1`: plane++, go to PREFETCH.
  - Otherwise: plane=0 and row++.
  - If row wrapped from `ROWS-1` to 0: pulse `frame_done`. Then go to PREFETCH if `enable=1`, else IDLE.
- `enable` falling mid-frame: the current frame completes, then the block enters IDLE. `enable` is not sampled elsewhere.
- `oe` is 1 in every state except DISPLAY. Row address never changes while `oe=0`.
- Colour data is the same bit plane for both halves; the lower half uses the same `{row,col}` address.

## Timing
- Reset values: colour outputs 0, `a..d`=0, `clkout`=0, `stb`=0, `oe`=1, `frame_done`=0, `busy`=0, `rd_addr`=0, state IDLE.
- Reset mid-operation forces these values immediately, with no completion of the current plane.
- Cycles per plane p: `1 + 2*COLS + 1 + (BASE_TICKS<<p)`. Defaults: p0 = 138, p3 = 194.
- Cycles per row: `BITS*(2*COLS+2) + BASE_TICKS*(2^BITS-1)`. Default: 640.
- Cycles per frame: `ROWS` × row time. Default: 10240.
- `frame_done` is asserted in the first cycle after the final DISPLAY, coincident with PREFETCH or IDLE.
- With `enable` held high, frames are back-to-back with no extra cycles.
- Display counter width: `log2(BASE_TICKS<<(BITS-1))+1`. No overflow allowed.

## Structure
- Package `matrix_pkg` holds:
  - state enum
  - `rd_data` field offsets
  - default `COLS`/`ROWS`/`BITS`/`BASE_TICKS`
- One sub-module, `bcm_timer`:
  - loadable down-counter; load value `BASE_TICKS<<plane`
  - outputs `active` (drives `oe` low) and a one-cycle `done`

## Test plan
- Reset released, `enable=0` for 100 cycles → `oe=1`, `busy=0`, `stb=0`, `clkout=0` throughout.
- `enable=1` with `rd_data` a constant pattern (r0 field = 4'b1010) → 64 `clkout` rising edges per plane. `r0` = 0,1,0,1 for planes 0..3. `stb` high exactly one cycle per plane.
- Measure `oe=0` run lengths on row 0 → exactly 8, 16, 32, 64 cycles. `a..d` = 0 during all of them, then 1 on the next row.
- Full frame with `enable` held → `frame_done` pulses every 10240 cycles, row sequence 0..15 then back to 0.
- Drop `enable` at row 7 → the block continues through row 15, pulses `frame_done`, then enters IDLE with `oe=1`.
- Assert `reset` during SHIFT of row 5 → all outputs reach reset values in the same cycle. After release with `enable=1`, scanning restarts at row 0, plane 0.
